// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory bus master for byte/half/word accesses.
// Optional build macro MISALIGN_TRAP_EN adds a misalign response instead of issuing unaligned H/W.
module load_store_unit #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [5:0]        ex_alucode,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              bus_err
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  // Memory op encodings shared with the decoder's define.vh
  localparam logic [5:0] ALU_LB  = 6'd22;
  localparam logic [5:0] ALU_LH  = 6'd23;
  localparam logic [5:0] ALU_LW  = 6'd24;
  localparam logic [5:0] ALU_LBU = 6'd25;
  localparam logic [5:0] ALU_LHU = 6'd26;
  localparam logic [5:0] ALU_SB  = 6'd27;
  localparam logic [5:0] ALU_SH  = 6'd28;
  localparam logic [5:0] ALU_SW  = 6'd29;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Counter only needs to reach TIMEOUT-1; the error fires on the cycle it sits there
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [3:0]        be_reg, be_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic [4:0]        rd_reg, rd_next;
  logic [1:0]        off_reg, off_next;
  logic [1:0]        size_reg, size_next;
  logic              uns_reg, uns_next;
  logic [31:0]       data_reg, data_next;
  logic              wbwe_reg, wbwe_next;
  logic              err_reg, err_next;
`ifdef MISALIGN_TRAP_EN
  logic              mis_reg, mis_next;
  logic              dec_mis;
`endif

  logic        dec_mem, dec_load, dec_uns;
  logic [1:0]  dec_size;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        timeout_hit;

  always_comb begin
    dec_mem  = 1'b1;
    dec_load = 1'b1;
    dec_size = SZ_W;
    dec_uns  = 1'b0;
    case (ex_alucode)
      ALU_LB:  dec_size = SZ_B;
      ALU_LH:  dec_size = SZ_H;
      ALU_LW:  dec_size = SZ_W;
      ALU_LBU: begin dec_size = SZ_B; dec_uns = 1'b1; end
      ALU_LHU: begin dec_size = SZ_H; dec_uns = 1'b1; end
      ALU_SB:  begin dec_size = SZ_B; dec_load = 1'b0; end
      ALU_SH:  begin dec_size = SZ_H; dec_load = 1'b0; end
      ALU_SW:  begin dec_size = SZ_W; dec_load = 1'b0; end
      default: begin dec_mem = 1'b0; dec_load = 1'b0; end
    endcase
  end

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = ex_wdata;
    case (dec_size)
      SZ_B: begin
        lane_be    = 4'b0001 << ex_addr[1:0];
        lane_wdata = {4{ex_wdata[7:0]}};
      end
      SZ_H: begin
        lane_be    = 4'b0011 << {ex_addr[1], 1'b0};
        lane_wdata = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign dec_mis = ((dec_size == SZ_H) && ex_addr[0]) ||
                   ((dec_size == SZ_W) && (ex_addr[1:0] != 2'b00));
`endif

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word;
    res = word;
    case (size)
      SZ_B: begin
        sh  = word >> {off, 3'b000};
        res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        sh  = word >> {off[1], 4'b0000};
        res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: res = word;
    endcase
    return res;
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;
    we_next    = we_reg;
    rd_next    = rd_reg;
    off_next   = off_reg;
    size_next  = size_reg;
    uns_next   = uns_reg;
    data_next  = data_reg;
    wbwe_next  = wbwe_reg;
    err_next   = err_reg;
`ifdef MISALIGN_TRAP_EN
    mis_next   = mis_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (ex_valid && dec_mem) begin
          addr_next  = {ex_addr[ADDR_W-1:2], 2'b00};
          be_next    = lane_be;
          wdata_next = lane_wdata;
          we_next    = ~dec_load;
          rd_next    = ex_rd;
          off_next   = ex_addr[1:0];
          size_next  = dec_size;
          uns_next   = dec_uns;
          data_next  = '0;
          wbwe_next  = 1'b0;
          err_next   = 1'b0;
          cnt_next   = '0;
          state_next = REQ;
`ifdef MISALIGN_TRAP_EN
          mis_next = dec_mis;
          if (dec_mis) state_next = RESP;
`endif
        end
      end
      REQ: begin
        cnt_next = cnt_reg + 1'b1;
        if (mem_gnt) begin
          if (we_reg) begin
            state_next = RESP;
          end else if (mem_rvalid) begin
            data_next  = extract(mem_rdata, off_reg, size_reg, uns_reg);
            wbwe_next  = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (mem_rvalid) begin
          data_next  = extract(mem_rdata, off_reg, size_reg, uns_reg);
          wbwe_next  = 1'b1;
          state_next = RESP;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
        wbwe_next  = 1'b0;
        err_next   = 1'b0;
        data_next  = '0;
`ifdef MISALIGN_TRAP_EN
        mis_next   = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      rd_reg    <= '0;
      off_reg   <= '0;
      size_reg  <= '0;
      uns_reg   <= 1'b0;
      data_reg  <= '0;
      wbwe_reg  <= 1'b0;
      err_reg   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      rd_reg    <= rd_next;
      off_reg   <= off_next;
      size_reg  <= size_next;
      uns_reg   <= uns_next;
      data_reg  <= data_next;
      wbwe_reg  <= wbwe_next;
      err_reg   <= err_next;
`ifdef MISALIGN_TRAP_EN
      mis_reg   <= mis_next;
`endif
    end
  end

  // Handshake outputs decode straight from state so reset removes them immediately
  assign ex_ready  = (state_reg == IDLE);
  assign mem_req   = (state_reg == REQ);
  assign mem_we    = mem_req & we_reg;
  assign mem_addr  = addr_reg;
  assign mem_be    = be_reg;
  assign mem_wdata = wdata_reg;
  assign wb_valid  = (state_reg == RESP);
  assign wb_we     = wb_valid & wbwe_reg;
  assign wb_rd     = rd_reg;
  assign wb_data   = wb_valid ? data_reg : 32'h0;
  assign bus_err   = wb_valid & err_reg;
`ifdef MISALIGN_TRAP_EN
  assign misalign  = wb_valid & mis_reg;
`endif

endmodule
